tft_spi_tx: RTL and testbench

- Byte-level 4-wire SPI transmitter that sits directly downstream of the scene renderer and the tft_init sequencer.
- Accepts bytes on a transmit/busy handshake and buffers them in a small FIFO.
- Serialises the bytes MSB-first, SPI mode 0, to the TFT panel, with a D/C line per byte.
- Keeps chip-select low across back-to-back bytes so pixel streams run without gaps.

---
 rtl/tft_pkg.sv | 23 ++
 rtl/tft_spi_tx_if.sv | 26 ++
 rtl/tft_spi_tx_sync_fifo.sv | 56 +++++
 rtl/tft_spi_tx.sv | 155 +++++++++++++++
 tb/tb_tft_spi_tx.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tft_pkg.sv
// Shared definitions for the TFT SPI path: D/C encoding, FSM states and
// the FIFO entry layout {dc, data[7:0]}.
package tft_pkg;

  localparam logic TFT_CMD  = 1'b0;
  localparam logic TFT_DATA = 1'b1;

  localparam int FIFO_W = 9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_HOLD = 2'd3
  } tft_state_e;

  typedef logic [FIFO_W-1:0] tft_entry_t;

  function automatic tft_entry_t pack_entry(input logic dc, input logic [7:0] data);
    return {dc, data};
  endfunction

endpackage

// File: rtl/tft_spi_tx_if.sv
// Byte write port between the renderer / init sequencer and the SPI transmitter.
// Handshake: a byte transfers on a clock edge where tft_transmit=1 and
// tft_busy=0; tft_data and tft_dc are sampled on that edge. A strobe seen while
// tft_busy=1 is discarded, so the master must hold off until busy drops.
interface tft_spi_tx_if;

  logic [7:0] tft_data;
  logic       tft_dc;
  logic       tft_transmit;
  logic       tft_busy;

  modport master (
    output tft_data,
    output tft_dc,
    output tft_transmit,
    input  tft_busy
  );

  modport slave (
    input  tft_data,
    input  tft_dc,
    input  tft_transmit,
    output tft_busy
  );

endinterface

// File: rtl/tft_spi_tx_sync_fifo.sv
// Small first-word-fall-through FIFO; dout shows the head entry whenever
// empty=0. Push and pop in the same cycle both take effect.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tft_spi_tx.sv
// Byte-level SPI mode-0 transmitter for the TFT panel: buffers {dc, byte}
// entries and shifts them MSB-first, keeping cs_n low across back-to-back bytes.
module tft_spi_tx
  import tft_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CS_HOLD    = 2
) (
  input  logic        clk,
  input  logic        rst,
  tft_spi_tx_if.slave bus,
  output logic        idle,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_dc,
  output tft_state_e  state_dbg
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int TMAX  = (CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD;
  localparam int TW    = $clog2(TMAX + 1);

  tft_state_e  state;
  logic [TW-1:0] tick;
  logic [2:0]  bit_idx;
  logic [6:0]  shreg;

  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  tft_entry_t  fifo_din;
  tft_entry_t  fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_next;

  logic        div_done;
  logic        hold_done;
  logic        last_bit;
  logic        to_idle;

  assign state_dbg = state;

  assign div_done  = (tick == TW'(CLK_DIV - 1));
  assign hold_done = (tick == TW'(CS_HOLD - 1));
  assign last_bit  = (bit_idx == 3'd7);

  assign fifo_push = bus.tft_transmit && !fifo_full;
  assign fifo_din  = pack_entry(bus.tft_dc, bus.tft_data);

  // A pop always coincides with loading the next byte into the shifter.
  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty) begin
      case (state)
        S_IDLE, S_HOLD: fifo_pop = 1'b1;
        S_HIGH:         fifo_pop = div_done && last_bit;
        default:        fifo_pop = 1'b0;
      endcase
    end
  end

  assign to_idle    = fifo_empty && ((state == S_IDLE) || ((state == S_HOLD) && hold_done));
  assign count_next = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      tick         <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      spi_cs_n     <= 1'b1;
      spi_sclk     <= 1'b0;
      spi_mosi     <= 1'b0;
      spi_dc       <= 1'b0;
      bus.tft_busy <= 1'b0;
      idle         <= 1'b1;
    end else begin
      bus.tft_busy <= (count_next == CW'(FIFO_DEPTH));
      idle         <= to_idle && !fifo_push;

      if (fifo_pop) begin
        state    <= S_LOW;
        tick     <= '0;
        bit_idx  <= '0;
        shreg    <= fifo_dout[6:0];
        spi_mosi <= fifo_dout[7];
        spi_dc   <= fifo_dout[8];
        spi_cs_n <= 1'b0;
        spi_sclk <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            tick <= '0;
          end
          S_LOW: begin
            if (div_done) begin
              tick     <= '0;
              spi_sclk <= 1'b1;
              state    <= S_HIGH;
            end else begin
              tick <= tick + TW'(1);
            end
          end
          S_HIGH: begin
            if (div_done) begin
              tick     <= '0;
              spi_sclk <= 1'b0;
              if (!last_bit) begin
                bit_idx  <= bit_idx + 3'd1;
                spi_mosi <= shreg[6];
                shreg    <= {shreg[5:0], 1'b0};
                state    <= S_LOW;
              end else begin
                state <= S_HOLD;
              end
            end else begin
              tick <= tick + TW'(1);
            end
          end
          S_HOLD: begin
            if (hold_done) begin
              tick     <= '0;
              spi_cs_n <= 1'b1;
              state    <= S_IDLE;
            end else begin
              tick <= tick + TW'(1);
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tft_spi_tx.sv
// Directed bench for tft_spi_tx: a driver pushes expected {dc, byte} entries
// into a queue; a bus monitor decodes the SPI lines and pops/compares.
module tb_tft_spi_tx;
  import tft_pkg::*;

  localparam int CLK_DIV    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int CS_HOLD    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       idle;
  logic       spi_cs_n;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_dc;
  tft_state_e state_dbg;

  tft_spi_tx_if tft_if ();

  tft_spi_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CS_HOLD    (CS_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (tft_if),
    .idle      (idle),
    .spi_cs_n  (spi_cs_n),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_dc    (spi_dc),
    .state_dbg (state_dbg)
  );

  // Clock and cycle counter (cyc = number of rising edges so far)
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  int         rise_q[$];
  int         cs_rise_cnt = 0;
  int         last_cs_rise = -1;
  int         last_cs_fall = -1;
  bit         mon_en = 1'b0;

  logic [7:0] t3_data [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic       t3_busy_before [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       t3_busy_after  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0] t5_data [3] = '{8'h3a, 8'h7b, 8'hd5};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Driver: strobe one byte for one cycle, starting at a falling edge.
  task automatic send(input logic dc, input logic [7:0] d, input logic exp_busy,
                      input bit expect_tx, output int acc);
    tft_if.tft_data     = d;
    tft_if.tft_dc       = dc;
    tft_if.tft_transmit = 1'b1;
    check("busy_at_strobe", tft_if.tft_busy, exp_busy);
    if (expect_tx) exp_q.push_back({dc, d});
    @(negedge clk);
    tft_if.tft_transmit = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    @(negedge clk);
    while (idle !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", idle, 1);
    @(negedge clk);
  endtask

  // Monitor: decode bytes at SCLK rising edges and track cs_n transitions.
  task automatic monitor_loop();
    logic       prev_sclk = 1'b0;
    logic       prev_cs   = 1'b1;
    logic       prev_dc   = 1'b0;
    logic       byte_dc   = 1'b0;
    logic [7:0] sh        = '0;
    int         nb        = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (spi_dc !== prev_dc) check("dc_change_sclk_low", spi_sclk, 0);
        if (spi_sclk === 1'b1 && prev_sclk === 1'b0) begin
          rise_q.push_back(cyc);
          check("cs_low_at_rise", spi_cs_n, 0);
          if (nb == 0) byte_dc = spi_dc;
          else check("dc_stable", spi_dc, byte_dc);
          sh = {sh[6:0], spi_mosi};
          nb++;
          if (nb == 8) begin
            nb = 0;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL extra_byte: got %0h expected none", {byte_dc, sh});
            end else begin
              check("byte", {byte_dc, sh}, exp_q.pop_front());
            end
          end
        end
        if (spi_cs_n === 1'b1 && prev_cs === 1'b0) begin
          cs_rise_cnt++;
          last_cs_rise = cyc;
          nb = 0;
        end
        if (spi_cs_n === 1'b0 && prev_cs === 1'b1) last_cs_fall = cyc;
      end
      prev_sclk = spi_sclk;
      prev_cs   = spi_cs_n;
      prev_dc   = spi_dc;
    end
  endtask

  initial begin
    int a, a2, base, n;
    tft_if.tft_data     = '0;
    tft_if.tft_dc       = 1'b0;
    tft_if.tft_transmit = 1'b0;
    fork
      monitor_loop();
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy", tft_if.tft_busy, 0);
    check("rst_idle", idle, 1);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_dc", spi_dc, 0);
    check("rst_state", state_dbg, S_IDLE);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);

    // Single data byte 0xA5
    rise_q.delete();
    base = cs_rise_cnt;
    send(TFT_DATA, 8'hA5, 1'b0, 1'b1, a);
    check("t1_cs_high_at_accept", spi_cs_n, 1);
    check("t1_idle_low", idle, 0);
    @(negedge clk);
    check("t1_cs_fall", spi_cs_n, 0);
    check("t1_state_low", state_dbg, S_LOW);
    wait_idle(200);
    check("t1_edges", rise_q.size(), 8);
    check("t1_first_rise", rise_q[0], a + CLK_DIV + 1);
    check("t1_cs_fall_cyc", last_cs_fall, a + 1);
    check("t1_cs_rise_cyc", last_cs_rise, a + 1 + 16 * CLK_DIV + CS_HOLD);
    check("t1_cs_rises", cs_rise_cnt - base, 1);

    // Command then data, no gap between bytes
    rise_q.delete();
    base = cs_rise_cnt;
    send(TFT_CMD, 8'h2C, 1'b0, 1'b1, a);
    @(negedge clk);
    send(TFT_DATA, 8'h3A, 1'b0, 1'b1, a2);
    wait_idle(300);
    check("t2_edges", rise_q.size(), 16);
    check("t2_gap", rise_q[8] - rise_q[7], 2 * CLK_DIV);
    check("t2_cs_rises", cs_rise_cnt - base, 1);

    // Fill the FIFO; the strobe issued while busy is dropped
    rise_q.delete();
    base = cs_rise_cnt;
    for (int i = 0; i < 6; i++) begin
      send(TFT_DATA, t3_data[i], t3_busy_before[i], (i < 5), a);
      check("t3_busy_after", tft_if.tft_busy, t3_busy_after[i]);
      @(negedge clk);
    end
    wait_idle(500);
    check("t3_edges", rise_q.size(), 40);
    check("t3_cs_rises", cs_rise_cnt - base, 1);

    // Reset in the middle of 0xFF, then a clean 0x01
    rise_q.delete();
    send(TFT_DATA, 8'hFF, 1'b0, 1'b0, a);
    n = 0;
    while (rise_q.size() < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_reached_bit3", rise_q.size(), 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_cs_n", spi_cs_n, 1);
    check("t4_sclk", spi_sclk, 0);
    check("t4_mosi", spi_mosi, 0);
    check("t4_busy", tft_if.tft_busy, 0);
    check("t4_idle", idle, 1);
    @(negedge clk);
    rise_q.delete();
    send(TFT_DATA, 8'h01, 1'b0, 1'b1, a);
    wait_idle(200);
    check("t4_edges", rise_q.size(), 8);

    // Renderer-style stream: wait for busy low, strobe, small gap
    rise_q.delete();
    base = cs_rise_cnt;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (tft_if.tft_busy === 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      send(TFT_DATA, t5_data[i], 1'b0, 1'b1, a);
      repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    wait_idle(400);
    check("t5_edges", rise_q.size(), 24);
    check("t5_cs_rises", cs_rise_cnt - base, 1);

    // Write landing in the cycle after the last falling edge
    rise_q.delete();
    base = cs_rise_cnt;
    send(TFT_DATA, 8'h5A, 1'b0, 1'b1, a);
    repeat (16 * CLK_DIV + 1) @(negedge clk);
    send(TFT_DATA, 8'hC3, 1'b0, 1'b1, a2);
    check("t6_cs_low_in_hold", spi_cs_n, 0);
    wait_idle(300);
    check("t6_edges", rise_q.size(), 16);
    check("t6_second_start", rise_q[8], a2 + CLK_DIV + 1);
    check("t6_cs_rises", cs_rise_cnt - base, 1);

    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
